// File: rtl/nano_run_ctrl.sv
// rtl/nano_run_ctrl.sv - memory port owner and load/run/dump sequencer for NanoCPU
module nano_run_ctrl #(
    parameter int RUN_LIMIT = 1000,
    parameter int DUMP_LEN  = 256
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        load_start,
    input  logic        run_start,
    input  logic        dump_start,
    input  logic        run_stop,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic        dp_valid,
    input  logic        dp_ready,
    output logic [15:0] dp_data,
    output logic        cpu_rst,
    input  logic [7:0]  cpu_address,
    input  logic [15:0] cpu_dataW,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    output logic [15:0] cpu_dataR,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_dataW,
    output logic        mem_ce,
    output logic        mem_we,
    input  logic [15:0] mem_dataR,
    output logic        busy,
    output logic [15:0] run_cycles
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

    localparam logic [7:0] DUMP_LAST = 8'(DUMP_LEN - 1);
    localparam int         RUN_LAST  = RUN_LIMIT - 1;

    state_t     state;
    logic [7:0] ptr;
    logic       run_done;

    // A limit of zero means the run only ends on run_stop.
    assign run_done = (RUN_LIMIT != 0) && (32'(run_cycles) == 32'(RUN_LAST));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 8'd0;
            run_cycles <= 16'd0;
            cpu_rst    <= 1'b1;
            ld_ready   <= 1'b0;
            dp_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        ptr      <= 8'd0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (dump_start) begin
                        state    <= DUMP;
                        ptr      <= 8'd0;
                        dp_valid <= 1'b1;
                        busy     <= 1'b1;
                    end else if (run_start) begin
                        state      <= RUN;
                        run_cycles <= 16'd0;
                        cpu_rst    <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        ptr <= ptr + 8'd1;
                        if (ld_last || ptr == 8'hFF) begin
                            state    <= IDLE;
                            ptr      <= 8'd0;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (run_stop || run_done) begin
                        state   <= IDLE;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                DUMP: begin
                    if (dp_ready) begin
                        ptr <= ptr + 8'd1;
                        if (ptr == DUMP_LAST) begin
                            state    <= IDLE;
                            ptr      <= 8'd0;
                            dp_valid <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux: the CPU only reaches memory while RUN; its last-cycle write still lands.
    always_comb begin
        mem_address = ptr;
        mem_dataW   = ld_data;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        case (state)
            LOAD: begin
                mem_ce = ld_valid;
                mem_we = ld_valid;
            end
            RUN: begin
                mem_address = cpu_address;
                mem_dataW   = cpu_dataW;
                mem_ce      = cpu_ce;
                mem_we      = cpu_we;
            end
            DUMP:    mem_ce = 1'b1;
            default: ;
        endcase
    end

    assign dp_data   = mem_dataR;
    assign cpu_dataR = mem_dataR;
endmodule
